serializer_tx: RTL and testbench
================================

Name: serializer_tx

Overview:
- Upstream partner of the 32-bit framed deserializer; converts parallel words into its serial frame format.
- Frame is two header bits '1','1', then DATA_W payload bits MSB first, then GAP_BITS idle zeros.
- One bit per bit-period of DIV clk cycles, generated with an internal clock-enable tick; no derived clock.
- Sits between the parallel test-pattern source (valid/ready) and the serial link.

Parameters:
- DATA_W, 32, payload width in bits.
- DIV, 8, clk cycles per serial bit. Legal range is >= 2.
- GAP_BITS, 2, zero bit-periods after each payload. Legal range is >= 1; it guarantees the line is low before the next header.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_W  parallel word to transmit.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can accept a word this cycle.
- data_out  output  1  serial line, registered.
- busy  output  1  frame in progress, from acceptance through the last gap bit.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, div_cnt=0, bit_cnt=0, shift register=0.
  - data_out=0, in_ready=0 while rst_n low, busy=0, frame_done=0.
  - A reset mid-frame aborts the frame immediately and drives data_out low. There is no partial resume.
- Bit tick:
  - div_cnt runs 0..DIV-1 continuously from reset and wraps.
  - tick = (div_cnt==DIV-1).
  - data_out changes only on tick edges.
- State IDLE:
  - in_ready=1, data_out=0.
  - Acceptance = in_valid & in_ready at a clk edge: latch data_in into the shift register and go to ARMED.
  - in_ready drops in the cycle after acceptance.
  - in_valid without ready is ignored; data_in is don't-care when not accepted.
- State ARMED: at the next tick edge strictly after acceptance, drive data_out=1 (header bit 0) and go to HDR.
  - If the acceptance edge is itself a tick edge, the first bit waits the full DIV cycles.
- State HDR: at the next tick edge, drive data_out=1 (header bit 1) and go to DATA with bit_cnt=0.
- State DATA:
  - Each tick edge drives data_out = word[DATA_W-1-bit_cnt], i.e. MSB first, then increments bit_cnt.
  - After bit 0 is driven, go to GAP with bit_cnt=0.
- State GAP:
  - Each tick edge drives data_out=0.
  - On the tick edge that ends the GAP_BITS-th gap bit-period: go to IDLE, pulse frame_done for one cycle, and in_ready=1 from the next cycle.
- Frame length: exactly 2+DATA_W+GAP_BITS bit-periods, i.e. 36*8=288 clk cycles at defaults.
  - Back-to-back words are accepted in the first IDLE cycle; no extra throttling.
- busy = (state != IDLE).
- Width rules:
  - bit_cnt width = clog2(max(DATA_W,GAP_BITS)+1).
  - div_cnt width = clog2(DIV).
  - No arithmetic overflow is permitted; counters clear on state exit.
- Simultaneous events:
  - in_valid arriving on the same edge that GAP returns to IDLE is not accepted; in_ready is still 0 that cycle.
  - Acceptance in the first IDLE cycle is legal.
- Illegal state encodings recover to IDLE with data_out=0.

Decomposition:
- Shared package serdes_pkg holds:
  - the state enum (IDLE, ARMED, HDR, DATA, GAP);
  - HDR_PATTERN=2'b11 and HDR_LEN=2;
  - default DATA_W and DIV, also reused by the deserializer.
- One sub-module, bit_tick_gen, is natural: the DIV counter producing tick, with clk and rst_n ports.
- Shift/FSM logic stays in serializer_tx.

Test Plan:
- Reset then idle 100 cycles -> data_out=0, in_ready=1 after rst_n rises, busy=0, frame_done never pulses.
- Send data_in=32'hA5A5_0F0F once -> serial sample at each tick reads 1,1, then bits of A5A50F0F MSB first, then 0,0. frame_done pulses exactly once. The frame occupies 36 bit-periods.
- Loopback into the deserializer, sending 32'hDEAD_BEEF and then 32'h0000_0001 back-to-back -> deserializer outputs the words in order. in_ready low for every cycle of each frame.
- Send data_in=32'h0 and 32'hFFFF_FFFF -> header still 1,1. The all-ones payload is followed by exactly 2 zero bit-periods before the next header.
- Assert rst_n=0 mid-DATA, at bit 10 -> data_out=0 asynchronously, busy=0. After release a fresh word transmits a complete correct frame.
- Hold in_valid=1 with data_in changing every cycle -> only the word present at each acceptance edge is transmitted. in_valid on the frame_done edge is not accepted; it is accepted one cycle later.

Source files
------------

// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types and constants for the framed serial link
package serdes_pkg;

    // Frame sequencing states shared by serializer and deserializer.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        HDR   = 3'd2,
        DATA  = 3'd3,
        GAP   = 3'd4
    } serdes_state_e;

    // Two-bit '11' header precedes every payload.
    localparam logic [1:0] HDR_PATTERN = 2'b11;
    localparam int HDR_LEN = 2;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DIV      = 8;
    localparam int DEF_GAP_BITS = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// rtl/bit_tick_gen.sv - free-running divider producing a one-cycle bit tick
// Ports: clk, rst_n (async active-low), tick (high in the last cycle of each bit-period).
module bit_tick_gen
    import serdes_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = (div_cnt_q == LAST);

endmodule

// File: rtl/serializer_tx.sv
// rtl/serializer_tx.sv - parallel word to framed serial bitstream transmitter
// Ports: clk, rst_n (async active-low), data_in/in_valid/in_ready (word handshake),
//        data_out (registered serial line), busy (frame in progress), frame_done (1-cycle pulse).
module serializer_tx
    import serdes_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DIV      = DEF_DIV,
    parameter int GAP_BITS = DEF_GAP_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(max_int(DATA_W, GAP_BITS) + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_BITS);

    serdes_state_e     state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              data_out_q, data_out_d;
    logic              frame_done_q, frame_done_d;
    logic              tick;

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign in_ready   = rst_n && (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign data_out   = data_out_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                data_out_d = 1'b0;
                bit_cnt_d  = '0;
                if (in_valid && in_ready) begin
                    shift_d = data_in;
                    state_d = ARMED;
                end
            end
            // Waits for the first tick strictly after acceptance, so an
            // acceptance on a tick edge still gets a full first bit-period.
            ARMED: begin
                if (tick) begin
                    data_out_d = HDR_PATTERN[1];
                    state_d    = HDR;
                end
            end
            HDR: begin
                if (tick) begin
                    data_out_d = HDR_PATTERN[0];
                    bit_cnt_d  = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    data_out_d = shift_q[DATA_W-1];
                    shift_d    = shift_q << 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            // GAP_BITS zero periods are driven; the tick after the last one
            // closes the frame, hence the compare against GAP_BITS itself.
            GAP: begin
                if (tick) begin
                    data_out_d = 1'b0;
                    if (bit_cnt_q == GAP_END) begin
                        bit_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                data_out_d = 1'b0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_serializer_tx.sv
// tb/tb_serializer_tx.sv - directed self-checking bench for serializer_tx
module tb_serializer_tx;
    import serdes_pkg::*;

    localparam int DATA_W   = 32;
    localparam int DIV      = 8;
    localparam int GAP_BITS = 2;
    localparam int FRAME    = HDR_LEN + DATA_W + GAP_BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              data_out;
    logic              busy;
    logic              frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    bit wiggle = 1'b0;

    serializer_tx #(.DATA_W(DATA_W), .DIV(DIV), .GAP_BITS(GAP_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; a tick edge is one where cyc becomes a multiple of DIV.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int c);
        return DATA_W'(c) * 32'h9E37_79B9 + 32'h0135_7911;
    endfunction

    task automatic send(input logic [DATA_W-1:0] w, input bit align, output int acc);
        @(negedge clk);
        if (align) while ((cyc + 1) % DIV != 0) @(negedge clk);
        in_valid = 1'b1;
        data_in  = w;
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    // Samples data_out at every tick after acceptance 'acc' and checks the frame
    // against word w; returns the cycle at which frame_done is expected.
    task automatic capture(input int acc, input logic [DATA_W-1:0] w, input string tag,
                           output int exp_done);
        logic [FRAME-1:0] bits = '0;
        int nb = 0, done_cnt = 0, done_at = -1, rdy_bad = 0, busy_bad = 0, guard = 0;
        int t1;
        t1       = (acc / DIV + 1) * DIV;
        exp_done = t1 + FRAME * DIV;
        while (cyc < exp_done && guard < 400) begin
            @(negedge clk);
            guard++;
            if (wiggle) data_in = mk(cyc + 1);
            if (cyc > acc && cyc % DIV == 0 && nb < FRAME) begin
                bits = {bits[FRAME-2:0], data_out};
                nb++;
            end
            if (frame_done) begin
                done_cnt++;
                done_at = cyc;
            end
            if (cyc < exp_done) begin
                if (in_ready) rdy_bad++;
                if (!busy)    busy_bad++;
            end
        end
        chk({tag, "_hdr"},     64'(bits[FRAME-1 -: HDR_LEN]), 64'(HDR_PATTERN));
        chk({tag, "_payload"}, 64'(bits[GAP_BITS +: DATA_W]), 64'(w));
        chk({tag, "_gap"},     64'(bits[GAP_BITS-1:0]), 64'(0));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        chk({tag, "_done_at"},  64'(done_at), 64'(exp_done));
        chk({tag, "_rdy_low"},  64'(rdy_bad), 64'(0));
        chk({tag, "_busy_hi"},  64'(busy_bad), 64'(0));
        chk({tag, "_idle"},     64'({busy, in_ready}), 64'(2'b01));
    endtask

    initial begin
        int acc, d, tgt, bad_out, bad_rdy, bad_busy, bad_done;

        // Reset, then 100 idle cycles.
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_dout",  64'(data_out), 64'(0));
        chk("rst_busy",  64'(busy), 64'(0));
        #2 rst_n = 1'b1;
        bad_out = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (data_out)   bad_out++;
            if (!in_ready)  bad_rdy++;
            if (busy)       bad_busy++;
            if (frame_done) bad_done++;
        end
        chk("idle_dout",  64'(bad_out), 64'(0));
        chk("idle_ready", 64'(bad_rdy), 64'(0));
        chk("idle_busy",  64'(bad_busy), 64'(0));
        chk("idle_done",  64'(bad_done), 64'(0));

        // Single word, accepted on a tick edge.
        send(32'hA5A5_0F0F, 1'b1, acc);
        chk("a5_acc_on_tick", 64'(acc % DIV), 64'(0));
        capture(acc, 32'hA5A5_0F0F, "a5", d);

        // Back-to-back: second word accepted in the first IDLE cycle.
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        acc     = cyc;
        data_in = 32'h0000_0001;
        capture(acc, 32'hDEAD_BEEF, "b2b0", d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        capture(d + 1, 32'h0000_0001, "b2b1", d);

        // All-zero and all-ones payloads.
        send(32'h0000_0000, 1'b0, acc);
        capture(acc, 32'h0000_0000, "zero", d);
        send(32'hFFFF_FFFF, 1'b0, acc);
        capture(acc, 32'hFFFF_FFFF, "ones", d);

        // Reset asserted while payload bit 10 is on the line.
        send(32'hFFFF_FFFF, 1'b0, acc);
        tgt = (acc / DIV + 1) * DIV + (HDR_LEN + 10) * DIV;
        while (cyc < tgt) @(negedge clk);
        chk("mid_bit10", 64'(data_out), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dout",  64'(data_out), 64'(0));
        chk("mid_rst_busy",  64'(busy), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(0));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(in_ready), 64'(1));
        send(32'h1234_5678, 1'b0, acc);
        capture(acc, 32'h1234_5678, "post_rst", d);

        // in_valid held high with data changing every cycle.
        @(negedge clk);
        wiggle   = 1'b1;
        in_valid = 1'b1;
        data_in  = mk(cyc + 1);
        @(posedge clk);
        #1;
        acc = cyc;
        capture(acc, mk(acc), "hold0", d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wiggle   = 1'b0;
        capture(d + 1, mk(d + 1), "hold1", d);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
